// File: rtl/gray_code_decoder.sv
// gray_code_decoder
// Receives an asynchronous Gray-coded counter value, synchronizes it with two
// flops, decodes it to binary and tracks legal +1 / -1 steps. Any other change
// is reported as an error, counted (saturating) and the tracker relocks on the
// new value. All outputs are registered; pulses last exactly one cycle.
// dbg_state exposes the FSM state (0 = UNLOCKED, 1 = TRACK, 2 = RELOCK).
module gray_code_decoder #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             en,
   output logic [WIDTH-1:0] bin_out,
   output logic             step_up,
   output logic             step_dn,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic             locked,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_TRACK    = 2'd1,
      ST_RELOCK   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
   logic [WIDTH-1:0] bin_out_q, bin_out_d;
   logic             step_up_q, step_up_d;
   logic             step_dn_q, step_dn_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             locked_q, locked_d;

   logic [WIDTH-1:0] cur_bin;
   logic [WIDTH-1:0] diff;
   logic             is_up, is_dn, is_bad;

   // Gray to binary: MSB copied, each lower bit is the XOR of all bits above and itself.
   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Two-flop synchronizer, always running regardless of en.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= gray_in;
         s2_q <= s1_q;
      end
   end

   // Classify the synchronized sample against the last accepted value (mod 2^WIDTH).
   always_comb begin
      cur_bin = g2b(s2_q);
      diff    = cur_bin - prev_bin_q;
      is_up   = (diff == WIDTH'(1));
      is_dn   = (diff == {WIDTH{1'b1}});
      is_bad  = (diff != '0) && !is_up && !is_dn;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= ST_UNLOCKED;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: disable wins in TRACK; an illegal step forces one RELOCK cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_UNLOCKED: if (en) state_d = ST_TRACK;
         ST_TRACK: begin
            if (!en)        state_d = ST_UNLOCKED;
            else if (is_bad) state_d = ST_RELOCK;
         end
         ST_RELOCK:   state_d = en ? ST_TRACK : ST_UNLOCKED;
         default:     state_d = ST_UNLOCKED;
      endcase
   end

   // FSM outputs and datapath next values; locked follows the state being entered.
   always_comb begin
      prev_bin_d  = prev_bin_q;
      bin_out_d   = bin_out_q;
      step_up_d   = 1'b0;
      step_dn_d   = 1'b0;
      err_d       = 1'b0;
      err_count_d = err_count_q;
      case (state_q)
         ST_UNLOCKED: begin
            if (en) begin
               prev_bin_d = cur_bin;
               bin_out_d  = cur_bin;
            end
         end
         ST_TRACK: begin
            if (en) begin
               if (is_up) begin
                  prev_bin_d = cur_bin;
                  bin_out_d  = cur_bin;
                  step_up_d  = 1'b1;
               end else if (is_dn) begin
                  prev_bin_d = cur_bin;
                  bin_out_d  = cur_bin;
                  step_dn_d  = 1'b1;
               end else if (is_bad) begin
                  err_d = 1'b1;
                  if (err_count_q != {ERR_W{1'b1}}) begin
                     err_count_d = err_count_q + ERR_W'(1);
                  end
               end
            end
         end
         ST_RELOCK: begin
            prev_bin_d = cur_bin;
            bin_out_d  = cur_bin;
         end
         default: ;
      endcase
      locked_d = (state_d == ST_TRACK);
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         prev_bin_q  <= '0;
         bin_out_q   <= '0;
         step_up_q   <= 1'b0;
         step_dn_q   <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
         locked_q    <= 1'b0;
      end else begin
         prev_bin_q  <= prev_bin_d;
         bin_out_q   <= bin_out_d;
         step_up_q   <= step_up_d;
         step_dn_q   <= step_dn_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
      end
   end

   assign bin_out   = bin_out_q;
   assign step_up   = step_up_q;
   assign step_dn   = step_dn_q;
   assign err       = err_q;
   assign err_count = err_count_q;
   assign locked    = locked_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_code_decoder.sv
// Directed bench for gray_code_decoder: reset, up/down walks with wrap,
// illegal jumps with a saturating second instance (ERR_W=2), enable gap
// and asynchronous reset mid-stream.
module tb_gray_code_decoder;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_;
   logic       en;
   logic [3:0] gray_in;

   always #5 clk = ~clk;

   logic [3:0] bin_out, bin_out2;
   logic       step_up, step_dn, err, locked;
   logic       step_up2, step_dn2, err2, locked2;
   logic [7:0] err_count;
   logic [1:0] err_count2;
   logic [1:0] dbg_state, dbg_state2;

   gray_code_decoder #(.WIDTH(4), .ERR_W(8)) dut (
      .clk(clk), .rst_(rst_), .gray_in(gray_in), .en(en),
      .bin_out(bin_out), .step_up(step_up), .step_dn(step_dn), .err(err),
      .err_count(err_count), .locked(locked), .dbg_state(dbg_state)
   );

   gray_code_decoder #(.WIDTH(4), .ERR_W(2)) dut_sat (
      .clk(clk), .rst_(rst_), .gray_in(gray_in), .en(en),
      .bin_out(bin_out2), .step_up(step_up2), .step_dn(step_dn2), .err(err2),
      .err_count(err_count2), .locked(locked2), .dbg_state(dbg_state2)
   );

   // ---------------- scoreboard counters ----------------
   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int up_cnt = 0;
   int dn_cnt = 0;
   int err_cnt = 0;
   int excl_viol = 0;

   // Pulse tallies and mutual-exclusion monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_ === 1'b1) begin
         if (step_up) up_cnt++;
         if (step_dn) dn_cnt++;
         if (err) err_cnt++;
         if ((int'(step_up) + int'(step_dn) + int'(err)) > 1) excl_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] to_gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   // Legal step to binary b: pulse appears exactly 3 edges after the change.
   task automatic do_step(input logic [3:0] b, input bit up);
      gray_in = to_gray(b);
      tick(2);
      chk("pulse_early", {30'd0, step_up, step_dn}, 32'd0);
      tick(1);
      chk("pulse_up", step_up, up);
      chk("pulse_dn", step_dn, !up);
      chk("step_bin", bin_out, b);
      chk("step_noerr", err, 0);
      tick(1);
      chk("pulse_end", {30'd0, step_up, step_dn}, 32'd0);
   endtask

   // Illegal jump to binary b from old: err pulse with bin_out held, then relock.
   task automatic do_jump(input logic [3:0] b, input logic [3:0] old,
                          input int exp_cnt, input int exp_sat);
      gray_in = to_gray(b);
      tick(2);
      chk("jump_early_err", err, 0);
      tick(1);
      chk("jump_err", err, 1);
      chk("jump_hold", bin_out, old);
      chk("jump_unlocked", locked, 0);
      chk("jump_cnt", err_count, exp_cnt);
      chk("jump_sat", err_count2, exp_sat);
      chk("jump_sat_err", err2, 1);
      tick(1);
      chk("relock_err", err, 0);
      chk("relock_locked", locked, 1);
      chk("relock_bin", bin_out, b);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_    = 1'b0;
      en      = 1'b1;
      gray_in = 4'b0000;
      #3;
      chk("rst_bin", bin_out, 0);
      chk("rst_locked", locked, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_pulses", {29'd0, step_up, step_dn, err}, 0);
      chk("rst_state", dbg_state, 0);
      tick(2);
      rst_ = 1'b1;
      chk("rel_locked_pre", locked, 0);
      tick(1);
      chk("rel_locked", locked, 1);
      chk("rel_bin", bin_out, 0);
      chk("rel_state", dbg_state, 1);
      chk("rel_pulses", {29'd0, step_up, step_dn, err}, 0);

      // Up walk 1..15 then wrap to 0.
      for (int b = 1; b <= 16; b++) do_step(4'(b), 1'b1);
      // Down walk 15..0 (first step wraps 0 -> 15).
      for (int k = 1; k <= 16; k++) do_step(4'(16 - k), 1'b0);
      chk("down_cnt", err_count, 0);

      // Illegal jumps: 1 -> 6 (Hamming distance 1 but |d|=5), then legal 6 -> 7.
      do_step(4'd1, 1'b1);
      do_jump(4'd6, 4'd1, 1, 1);
      do_step(4'd7, 1'b1);
      do_jump(4'd0, 4'd7, 2, 2);
      do_jump(4'd2, 4'd0, 3, 3);
      do_jump(4'd4, 4'd2, 4, 3);
      do_jump(4'd8, 4'd4, 5, 3);

      // Enable gap: park at 3 without tracking, then move to 9 while disabled.
      en = 1'b0;
      tick(1);
      chk("dis_locked", locked, 0);
      chk("dis_state", dbg_state, 0);
      gray_in = to_gray(4'd3);
      tick(3);
      chk("dis_hold", bin_out, 8);
      chk("dis_noerr", err, 0);
      en = 1'b1;
      tick(1);
      chk("en_locked", locked, 1);
      chk("en_bin3", bin_out, 3);
      en = 1'b0;
      tick(1);
      chk("gap_locked", locked, 0);
      gray_in = to_gray(4'd9);
      tick(3);
      chk("gap_hold", bin_out, 3);
      chk("gap_noerr", err, 0);
      en = 1'b1;
      tick(1);
      chk("gap_relock", locked, 1);
      chk("gap_bin9", bin_out, 9);
      chk("gap_err", err, 0);
      chk("gap_cnt", err_count, 5);
      tick(1);
      chk("gap_err2", err, 0);

      // Asynchronous reset mid-stream clears immediately.
      gray_in = to_gray(4'd10);
      tick(2);
      #2;
      rst_ = 1'b0;
      #1;
      chk("mid_rst_bin", bin_out, 0);
      chk("mid_rst_cnt", err_count, 0);
      chk("mid_rst_sat", err_count2, 0);
      chk("mid_rst_locked", locked, 0);
      gray_in = 4'b0000;
      tick(3);
      rst_ = 1'b1;
      tick(1);
      chk("post_rst_locked", locked, 1);
      chk("post_rst_bin", bin_out, 0);
      tick(3);
      chk("post_rst_quiet", {29'd0, step_up, step_dn, err}, 0);

      // Pulse totals over the whole run.
      chk("tot_up", up_cnt, 18);
      chk("tot_dn", dn_cnt, 16);
      chk("tot_err", err_cnt, 5);
      chk("exclusive", excl_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
